quant_writeback: RTL and testbench

Output write-back stage directly downstream of the quantizer. It accepts one row of ARRAY_SIZE quantized 32-bit results per handshake and buffers the row. It serializes the row into SRAM_DATA_WIDTH-wide SRAM write beats at consecutive addresses from a programmable base. It counts NUM_ROWS rows per tile, then pulses done.

---
 rtl/quant_writeback_pkg.sv | 26 ++
 rtl/quant_writeback_wb_addr_gen.sv | 61 ++++++
 rtl/quant_writeback.sv | 93 +++++++++
 tb/tb_quant_writeback.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/quant_writeback_pkg.sv
// Shared types and sizing helpers for the quantizer write-back stage.
package quant_writeback_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ROW = 2'd1,
    WRITE    = 2'd2,
    DONE     = 2'd3
  } wbState_e;

  function automatic int cntWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int elemsPerBeat(input int sramW, input int outW);
    return sramW / outW;
  endfunction

  function automatic int beatsPerRow(input int arraySize, input int epb);
    return arraySize / epb;
  endfunction

  localparam int EPB   = elemsPerBeat(64, 32);
  localparam int BEATS = beatsPerRow(32, EPB);

endpackage

// File: rtl/quant_writeback_wb_addr_gen.sv
// Base/row/beat counters for the write-back stage; produces the SRAM address
// and the last-beat / last-row flags consumed by the FSM.
module wb_addr_gen
  import quant_writeback_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BEATS_P    = 16,
  parameter int NUM_ROWS   = 32,
  localparam int BW        = cntWidth(BEATS_P),
  localparam int RW        = cntWidth(NUM_ROWS)
) (
  input  logic                  clk,
  input  logic                  srst_n,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic                  capture_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [BW-1:0]         beat_o,
  output logic                  lastBeat_o,
  output logic                  lastRow_o
);

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [RW-1:0]         row_q, row_d;
  logic [BW-1:0]         beat_q, beat_d;

  always_comb begin
    base_d = base_q;
    row_d  = row_q;
    beat_d = beat_q;
    if (load_i) begin
      base_d = base_i;
      row_d  = '0;
      beat_d = '0;
    end else begin
      // The row advances on the last beat so WAIT_ROW already sees the next row's offset.
      if (advance_i && lastBeat_o && !lastRow_o) row_d = row_q + 1'b1;
      if (capture_i)      beat_d = '0;
      else if (advance_i) beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      base_q <= '0;
      row_q  <= '0;
      beat_q <= '0;
    end else begin
      base_q <= base_d;
      row_q  <= row_d;
      beat_q <= beat_d;
    end
  end

  assign lastBeat_o = (beat_q == BW'(BEATS_P - 1));
  assign lastRow_o  = (row_q == RW'(NUM_ROWS - 1));
  assign beat_o     = beat_q;
  assign addr_o     = base_q + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(BEATS_P) + ADDR_WIDTH'(beat_q);

endmodule

// File: rtl/quant_writeback.sv
// Quantizer write-back: buffers one row per handshake and serializes it into
// consecutive SRAM write beats, pulsing done after the last row of a tile.
module quant_writeback
  import quant_writeback_pkg::*;
#(
  parameter int ARRAY_SIZE        = 32,
  parameter int OUTPUT_DATA_WIDTH = 32,
  parameter int SRAM_DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH        = 10,
  parameter int NUM_ROWS          = 32
) (
  input  logic                                    clk,
  input  logic                                    srst_n,
  input  logic                                    start,
  input  logic [ADDR_WIDTH-1:0]                   base_addr,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] in_data,
  output logic                                    sram_we,
  output logic [ADDR_WIDTH-1:0]                   sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0]              sram_wdata,
  output logic                                    busy,
  output logic                                    done
);

  localparam int EPB_P   = elemsPerBeat(SRAM_DATA_WIDTH, OUTPUT_DATA_WIDTH);
  localparam int BEATS_P = beatsPerRow(ARRAY_SIZE, EPB_P);
  localparam int BW      = cntWidth(BEATS_P);

  wbState_e state_q, state_d;
  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] rowBuf_q, rowBuf_d;

  logic [ADDR_WIDTH-1:0] genAddr;
  logic [BW-1:0]         beatCnt;
  logic                  lastBeat, lastRow, handshake, load;

  wb_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BEATS_P    (BEATS_P),
    .NUM_ROWS   (NUM_ROWS)
  ) u_addr_gen (
    .clk        (clk),
    .srst_n     (srst_n),
    .load_i     (load),
    .base_i     (base_addr),
    .capture_i  (handshake),
    .advance_i  (state_q == WRITE),
    .addr_o     (genAddr),
    .beat_o     (beatCnt),
    .lastBeat_o (lastBeat),
    .lastRow_o  (lastRow)
  );

  assign in_ready  = (state_q == WAIT_ROW) || ((state_q == WRITE) && lastBeat && !lastRow);
  assign handshake = in_valid && in_ready;
  assign load      = (state_q == IDLE) && start;

  always_comb begin
    state_d  = state_q;
    rowBuf_d = rowBuf_q;
    if (handshake) rowBuf_d = in_data;
    case (state_q)
      IDLE:     if (start) state_d = WAIT_ROW;
      WAIT_ROW: if (handshake) state_d = WRITE;
      WRITE: begin
        if (lastBeat) begin
          if (lastRow)        state_d = DONE;
          else if (handshake) state_d = WRITE;
          else                state_d = WAIT_ROW;
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q  <= IDLE;
      rowBuf_q <= '0;
    end else begin
      state_q  <= state_d;
      rowBuf_q <= rowBuf_d;
    end
  end

  assign sram_we    = (state_q == WRITE);
  assign sram_addr  = sram_we ? genAddr : '0;
  assign sram_wdata = sram_we ? rowBuf_q[beatCnt*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH] : '0;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_quant_writeback.sv
// Self-checking bench: two write-back instances (10-bit and 4-bit address) share
// stimulus and are compared every cycle against a beat-queue reference model.
module tb_quant_writeback;

  localparam int AS  = 4;
  localparam int OW  = 32;
  localparam int SW  = 64;
  localparam int AW  = 10;
  localparam int AWS = 4;
  localparam int NR  = 2;
  localparam int BT  = AS / (SW / OW);

  logic            clk = 1'b0;
  logic            srst_n, start, in_valid;
  logic [AW-1:0]   base_addr;
  logic [AS*OW-1:0] in_data;

  logic            readyA, weA, busyA, doneA;
  logic [AW-1:0]   addrA;
  logic [SW-1:0]   wdataA;
  logic            readyB, weB, busyB, doneB;
  logic [AWS-1:0]  addrB;
  logic [SW-1:0]   wdataB;

  quant_writeback #(.ARRAY_SIZE(AS), .OUTPUT_DATA_WIDTH(OW), .SRAM_DATA_WIDTH(SW),
                    .ADDR_WIDTH(AW), .NUM_ROWS(NR)) dutA (
    .clk(clk), .srst_n(srst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(readyA), .in_data(in_data),
    .sram_we(weA), .sram_addr(addrA), .sram_wdata(wdataA), .busy(busyA), .done(doneA));

  quant_writeback #(.ARRAY_SIZE(AS), .OUTPUT_DATA_WIDTH(OW), .SRAM_DATA_WIDTH(SW),
                    .ADDR_WIDTH(AWS), .NUM_ROWS(NR)) dutB (
    .clk(clk), .srst_n(srst_n), .start(start), .base_addr(base_addr[AWS-1:0]),
    .in_valid(in_valid), .in_ready(readyB), .in_data(in_data),
    .sram_we(weB), .sram_addr(addrB), .sram_wdata(wdataB), .busy(busyB), .done(doneB));

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   addr;
    logic [SW-1:0] data;
  } beat_t;

  // Model: a tile is a queue of pending beats; the head is what the SRAM should see now.
  beat_t       beatQ[$];
  beat_t       wrLog[$];
  bit          mBusy, mDone;
  int          mRows;
  int unsigned mBase;

  int compared   = 0;
  int mismatched = 0;

  task automatic check1(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s timeout observed=waiting expected=completion", tag);
  endtask

  function automatic logic [AS*OW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit modelReady();
    return mBusy && !mDone && (mRows < NR) && (beatQ.size() <= 1);
  endfunction

  task automatic checkOutput();
    logic          we;
    logic [AW-1:0] ea;
    logic [SW-1:0] ed;
    we = (beatQ.size() > 0);
    ea = we ? AW'(beatQ[0].addr) : '0;
    ed = we ? beatQ[0].data : '0;
    check1("weA",    64'(weA),    64'(we));
    check1("weB",    64'(weB),    64'(we));
    check1("addrA",  64'(addrA),  64'(ea));
    check1("addrB",  64'(addrB),  64'(ea[AWS-1:0]));
    check1("wdataA", wdataA,      ed);
    check1("wdataB", wdataB,      ed);
    check1("readyA", 64'(readyA), 64'(modelReady()));
    check1("readyB", 64'(readyB), 64'(modelReady()));
    check1("busyA",  64'(busyA),  64'(mBusy));
    check1("busyB",  64'(busyB),  64'(mBusy));
    check1("doneA",  64'(doneA),  64'(mDone));
    check1("doneB",  64'(doneB),  64'(mDone));
  endtask

  task automatic modelStep();
    bit rdy, popped;
    beat_t nb;
    rdy    = modelReady();
    popped = 1'b0;
    if (!mBusy) begin
      if (start) begin
        mBusy = 1'b1;
        mBase = int'(base_addr);
        mRows = 0;
      end
    end else if (mDone) begin
      mDone = 1'b0;
      mBusy = 1'b0;
    end else begin
      if (beatQ.size() > 0) begin
        void'(beatQ.pop_front());
        popped = 1'b1;
      end
      if (rdy && in_valid) begin
        for (int b = 0; b < BT; b++) begin
          nb.addr = mBase + int'(mRows * BT + b);
          nb.data = in_data[b*SW +: SW];
          beatQ.push_back(nb);
        end
        mRows++;
      end
      if (popped && beatQ.size() == 0 && mRows == NR) mDone = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [AW-1:0] ba, input logic vl,
                               input logic [AS*OW-1:0] dat);
    beat_t lg;
    start     = st;
    base_addr = ba;
    in_valid  = vl;
    in_data   = dat;
    #1;
    checkOutput();
    if (weA === 1'b1) begin
      lg.addr = int'(addrA);
      lg.data = wdataA;
      wrLog.push_back(lg);
    end
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    srst_n    = 1'b0;
    start     = 1'b1;
    in_valid  = 1'b1;
    in_data   = rand128();
    base_addr = AW'($urandom);
    beatQ.delete();
    mBusy = 1'b0;
    mDone = 1'b0;
    mRows = 0;
    #1;
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
    srst_n   = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic offerRow(input logic [AS*OW-1:0] dat);
    int r0, n;
    r0 = mRows;
    n  = 0;
    while (mRows == r0 && n < 20) begin
      applyStimulus(1'b0, base_addr, 1'b1, dat);
      n++;
    end
    if (mRows == r0) timeoutFail("offerRow");
  endtask

  task automatic drainIdle(input logic vl, input int limit);
    int n;
    n = 0;
    while (mBusy && n < limit) begin
      applyStimulus(1'b0, base_addr, vl, rand128());
      n++;
    end
    if (mBusy) timeoutFail("drainIdle");
    applyStimulus(1'b0, base_addr, 1'b0, '0);
  endtask

  initial begin
    logic [63:0] expAddr [4];
    logic [63:0] expData [4];
    expAddr = '{64'h010, 64'h011, 64'h012, 64'h013};
    expData = '{64'h00000001_00000000, 64'h00000003_00000002,
                64'h00000005_00000004, 64'h00000007_00000006};

    // Reset with start/in_valid held high, then idle: nothing may start.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, AW'($urandom), 1'b1, rand128());

    // Single tile with known rows at base 0x010.
    wrLog.delete();
    applyStimulus(1'b1, 10'h010, 1'b0, '0);
    applyStimulus(1'b0, 10'h010, 1'b0, '0);
    offerRow({32'd3, 32'd2, 32'd1, 32'd0});
    while (modelReady() == 1'b0 && mBusy && mRows < NR) applyStimulus(1'b0, 10'h010, 1'b0, '0);
    offerRow({32'd7, 32'd6, 32'd5, 32'd4});
    drainIdle(1'b0, 20);
    check1("t2_beats", 64'(wrLog.size()), 64'd4);
    for (int i = 0; i < 4 && i < wrLog.size(); i++) begin
      check1("t2_addr", 64'(wrLog[i].addr), expAddr[i]);
      check1("t2_data", wrLog[i].data, expData[i]);
    end

    // Streaming: in_valid held high, row1 presented as soon as row0 is taken.
    applyStimulus(1'b1, 10'h020, 1'b0, '0);
    for (int c = 0; c < 8 && mBusy; c++)
      applyStimulus(1'b0, 10'h020, 1'b1, (mRows == 0) ? {32'hA3, 32'hA2, 32'hA1, 32'hA0}
                                                      : {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    drainIdle(1'b1, 20);

    // Address wrap: 0x3FF on the wide instance, 0xF on the narrow one.
    applyStimulus(1'b1, 10'h3FF, 1'b0, '0);
    drainIdle(1'b1, 20);

    // Abuse: start with a new base mid-write, data toggled without valid, then reset mid-row.
    applyStimulus(1'b1, 10'h100, 1'b0, '0);
    offerRow(rand128());
    applyStimulus(1'b1, 10'h2AA, 1'b0, rand128());
    applyStimulus(1'b0, 10'h2AA, 1'b0, rand128());
    drainIdle(1'b1, 20);
    applyStimulus(1'b1, 10'h040, 1'b0, '0);
    offerRow(rand128());
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, AW'($urandom), 1'b0, rand128());

    // Randomized traffic, including stray starts and one reset mid-tile.
    for (int t = 0; t < 6; t++) begin
      applyStimulus(1'b1, AW'($urandom), 1'b0, '0);
      for (int c = 0; c < 30; c++)
        applyStimulus(($urandom_range(0, 7) == 0), AW'($urandom), 1'($urandom_range(0, 1)), rand128());
      if (t == 3) doReset();
      drainIdle(1'b1, 100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
